// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the multi-bank frame buffer: bank life-cycle
// states, reader states and the round-robin bank wrap.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_t;

  // Successor of a bank in round-robin order.
  function automatic int next_bank(input int ptr, input int num_banks);
    return (ptr + 1 >= num_banks) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port frame storage: one write port, one registered read port
// whose output holds its value when no read is issued.
module frame_buf_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 48,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset so it maps onto block RAM; only the
  // read register is cleared, which is all the outside world can observe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buf_multi.sv
// N-bank frame buffer: writer fills banks round-robin, reader drains completed
// banks in the same order, optionally repeating the newest frame.
module frame_buf_multi
  import frame_buf_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FRAME_WORDS = 16,
  parameter int NUM_BANKS   = 3,
  parameter int REPEAT_LAST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_in,
  input  logic              wr_sof_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_sof,
  output logic              rd_empty,
  output logic              wr_full,
  output logic              wr_overflow,
  output logic              wr_frame_done
);

  localparam int AW = $clog2(FRAME_WORDS);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int DEPTH = NUM_BANKS * FRAME_WORDS;
  localparam int MW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WORDS - 1);

  bank_state_t bank_st [NUM_BANKS];
  bank_state_t bank_nx [NUM_BANKS];
  rd_state_t   rd_st, rd_st_nx;

  logic [BW-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx, wr_nb, rd_nb;
  logic [AW-1:0] wr_addr, wr_addr_nx, rd_addr, rd_addr_nx;
  logic          wr_full_nx, rd_valid_nx, rd_sof_nx, wr_ovf_nx, wr_done_nx;
  logic          ram_we, ram_re;
  logic [MW-1:0] ram_waddr, ram_raddr;

  assign wr_nb    = BW'(next_bank(int'(wr_ptr), NUM_BANKS));
  assign rd_nb    = BW'(next_bank(int'(rd_ptr), NUM_BANKS));
  assign rd_empty = (rd_st == RD_IDLE);

  // Writer and reader only ever touch banks in disjoint states, so their
  // bank_nx updates below can never collide on the same index.
  // NOTE: every output of this block is defaulted first and assigned with
  // blocking '=' so it stays purely combinational with no inferred latch.
  always_comb begin
    bank_nx     = bank_st;
    wr_ptr_nx   = wr_ptr;
    wr_addr_nx  = wr_addr;
    wr_full_nx  = wr_full;
    wr_ovf_nx   = 1'b0;
    wr_done_nx  = 1'b0;
    rd_st_nx    = rd_st;
    rd_ptr_nx   = rd_ptr;
    rd_addr_nx  = rd_addr;
    rd_valid_nx = 1'b0;
    rd_sof_nx   = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    if (!wr_full) begin
      if (wr_sof_in) begin
        wr_addr_nx = '0;
      end else if (wr_en_in) begin
        ram_we = 1'b1;
        if (wr_addr == LAST_ADDR) begin
          bank_nx[wr_ptr] = BANK_FULL;
          wr_done_nx      = 1'b1;
          wr_addr_nx      = '0;
          if (bank_st[wr_nb] == BANK_FREE) begin
            wr_ptr_nx      = wr_nb;
            bank_nx[wr_nb] = BANK_WRITING;
          end else begin
            wr_full_nx = 1'b1;
          end
        end else begin
          wr_addr_nx = wr_addr + AW'(1);
        end
      end
    end else begin
      wr_ovf_nx = wr_en_in;
      if (bank_st[wr_nb] == BANK_FREE) begin
        wr_ptr_nx      = wr_nb;
        bank_nx[wr_nb] = BANK_WRITING;
        wr_full_nx     = 1'b0;
        wr_addr_nx     = '0;
      end
    end

    case (rd_st)
      RD_IDLE: begin
        if (bank_st[rd_ptr] == BANK_FULL) begin
          bank_nx[rd_ptr] = BANK_READING;
          rd_st_nx        = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (rd_en_in) begin
          ram_re      = 1'b1;
          rd_valid_nx = 1'b1;
          rd_sof_nx   = (rd_addr == '0);
          if (rd_addr == LAST_ADDR) begin
            rd_addr_nx = '0;
            if (bank_st[rd_nb] == BANK_FULL) begin
              bank_nx[rd_ptr] = BANK_FREE;
              bank_nx[rd_nb]  = BANK_READING;
              rd_ptr_nx       = rd_nb;
            end else if (REPEAT_LAST == 0) begin
              bank_nx[rd_ptr] = BANK_FREE;
              rd_ptr_nx       = rd_nb;
              rd_st_nx        = RD_IDLE;
            end
          end else begin
            rd_addr_nx = rd_addr + AW'(1);
          end
        end
      end
      default: rd_st_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_st[i] <= (i == 0) ? BANK_WRITING : BANK_FREE;
      end
      wr_ptr        <= '0;
      wr_addr       <= '0;
      wr_full       <= 1'b0;
      wr_overflow   <= 1'b0;
      wr_frame_done <= 1'b0;
      rd_st         <= RD_IDLE;
      rd_ptr        <= '0;
      rd_addr       <= '0;
      rd_valid      <= 1'b0;
      rd_sof        <= 1'b0;
    end else begin
      bank_st       <= bank_nx;
      wr_ptr        <= wr_ptr_nx;
      wr_addr       <= wr_addr_nx;
      wr_full       <= wr_full_nx;
      wr_overflow   <= wr_ovf_nx;
      wr_frame_done <= wr_done_nx;
      rd_st         <= rd_st_nx;
      rd_ptr        <= rd_ptr_nx;
      rd_addr       <= rd_addr_nx;
      rd_valid      <= rd_valid_nx;
      rd_sof        <= rd_sof_nx;
    end
  end

  assign ram_waddr = MW'(wr_ptr) * MW'(FRAME_WORDS) + MW'(wr_addr);
  assign ram_raddr = MW'(rd_ptr) * MW'(FRAME_WORDS) + MW'(rd_addr);

  frame_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (MW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_frame_buf_multi.sv
// Directed bench: two instances (REPEAT_LAST=0 and 1) share stimulus; each
// scenario task checks the instance it targets against hand-derived values.
module tb_frame_buf_multi;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_sof, rd_en;
  logic [31:0] data_in;

  logic [31:0] data_out0, data_out1;
  logic        rd_valid0, rd_sof0, rd_empty0, wr_full0, wr_overflow0, wr_done0;
  logic        rd_valid1, rd_sof1, rd_empty1, wr_full1, wr_overflow1, wr_done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_buf_multi #(.DATA_W(32), .FRAME_WORDS(4), .NUM_BANKS(3), .REPEAT_LAST(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en), .wr_sof_in(wr_sof), .data_in(data_in),
    .rd_en_in(rd_en), .data_out(data_out0), .rd_valid(rd_valid0), .rd_sof(rd_sof0),
    .rd_empty(rd_empty0), .wr_full(wr_full0), .wr_overflow(wr_overflow0),
    .wr_frame_done(wr_done0)
  );

  frame_buf_multi #(.DATA_W(32), .FRAME_WORDS(4), .NUM_BANKS(3), .REPEAT_LAST(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en), .wr_sof_in(wr_sof), .data_in(data_in),
    .rd_en_in(rd_en), .data_out(data_out1), .rd_valid(rd_valid1), .rd_sof(rd_sof1),
    .rd_empty(rd_empty1), .wr_full(wr_full1), .wr_overflow(wr_overflow1),
    .wr_frame_done(wr_done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; wr_sof = 1'b0; rd_en = 1'b0; data_in = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write_frame(input int base);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = base + i;
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_sof = 1'b0; rd_en = 1'b0; data_in = 32'hdead_beef;
    step();
    step();
    checks++;
    if ({data_out0, rd_valid0, rd_sof0, rd_empty0, wr_full0, wr_overflow0, wr_done0}
        !== {32'd0, 6'b001000}) begin
      errors++;
      $display("FAIL reset_dut0: got %h/%b%b%b%b%b%b expected 0/001000", data_out0,
               rd_valid0, rd_sof0, rd_empty0, wr_full0, wr_overflow0, wr_done0);
    end
    checks++;
    if ({data_out1, rd_valid1, rd_sof1, rd_empty1, wr_full1, wr_overflow1, wr_done1}
        !== {32'd0, 6'b001000}) begin
      errors++;
      $display("FAIL reset_dut1: got %h/%b%b%b%b%b%b expected 0/001000", data_out1,
               rd_valid1, rd_sof1, rd_empty1, wr_full1, wr_overflow1, wr_done1);
    end
    reset = 1'b0; rd_en = 1'b1;
    step();
    checks++;
    if ({rd_valid0, rd_empty0} !== 2'b01) begin
      errors++;
      $display("FAIL read_while_empty: valid/empty=%b%b expected 01", rd_valid0, rd_empty0);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; data_in = i;
      step();
      checks++;
      if (wr_done0 !== (i == 4)) begin
        errors++;
        $display("FAIL basic_frame_done[%0d]: got %b expected %b", i, wr_done0, i == 4);
      end
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (rd_empty0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_claim: rd_empty=%b expected 0", rd_empty0);
    end
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({rd_valid0, rd_sof0, data_out0} !== {1'b1, i == 1, 32'(i)}) begin
        errors++;
        $display("FAIL basic_read[%0d]: valid=%b sof=%b data=%0d expected 1 %b %0d",
                 i, rd_valid0, rd_sof0, data_out0, i == 1, i);
      end
    end
    checks++;
    if (rd_empty0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_empty_after: rd_empty=%b expected 1", rd_empty0);
    end
    step();
    checks++;
    if (rd_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_valid: rd_valid=%b expected 0", rd_valid0);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_repeat_last();
    int exp;
    do_reset();
    write_frame(1);
    step();
    rd_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wr_en   = (k >= 3 && k <= 6);
      data_in = 5 + k - 3;
      step();
      exp = (k < 8) ? (k % 4) + 1 : k - 8 + 5;
      checks++;
      if ({rd_valid1, rd_sof1, data_out1} !== {1'b1, (k % 4) == 0, 32'(exp)}) begin
        errors++;
        $display("FAIL repeat_read[%0d]: valid=%b sof=%b data=%0d expected 1 %b %0d",
                 k, rd_valid1, rd_sof1, data_out1, (k % 4) == 0, exp);
      end
      if (k == 6) begin
        checks++;
        if (wr_done1 !== 1'b1) begin
          errors++;
          $display("FAIL repeat_frame_done: got %b expected 1", wr_done1);
        end
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_overflow();
    int ovf = 0;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; data_in = i;
      step();
      ovf += int'(wr_overflow0);
      checks++;
      if ({wr_full0, wr_overflow0} !== {i >= 12, i >= 13}) begin
        errors++;
        $display("FAIL ovf_write[%0d]: full=%b overflow=%b expected %b %b",
                 i, wr_full0, wr_overflow0, i >= 12, i >= 13);
      end
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (wr_overflow0 !== 1'b0 || ovf != 4) begin
      errors++;
      $display("FAIL ovf_count: pulses=%0d last=%b expected 4 0", ovf, wr_overflow0);
    end
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({rd_valid0, data_out0, wr_full0} !== {1'b1, 32'(i), 1'b1}) begin
        errors++;
        $display("FAIL ovf_read[%0d]: valid=%b data=%0d full=%b expected 1 %0d 1",
                 i, rd_valid0, data_out0, wr_full0, i);
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (wr_full0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_release: wr_full=%b expected 0", wr_full0);
    end
    rd_en = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      step();
      checks++;
      if ({rd_valid0, data_out0} !== {1'b1, 32'(i)}) begin
        errors++;
        $display("FAIL ovf_read2[%0d]: valid=%b data=%0d expected 1 %0d", i, rd_valid0, data_out0, i);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_sof_and_reset();
    do_reset();
    wr_en = 1'b1; data_in = 9;
    step();
    step();
    wr_sof = 1'b1; data_in = 7;
    step();
    wr_sof = 1'b0;
    write_frame(1);
    checks++;
    if (wr_done0 !== 1'b1) begin
      errors++;
      $display("FAIL sof_frame_done: got %b expected 1", wr_done0);
    end
    step();
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({rd_valid0, rd_sof0, data_out0} !== {1'b1, i == 1, 32'(i)}) begin
        errors++;
        $display("FAIL sof_read[%0d]: valid=%b sof=%b data=%0d expected 1 %b %0d",
                 i, rd_valid0, rd_sof0, data_out0, i == 1, i);
      end
    end
    rd_en = 1'b0;
    write_frame(11);
    step();
    rd_en = 1'b1;
    step();
    step();
    checks++;
    if ({rd_valid0, data_out0} !== {1'b1, 32'd12}) begin
      errors++;
      $display("FAIL midread: valid=%b data=%0d expected 1 12", rd_valid0, data_out0);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({rd_valid0, rd_empty0} !== 2'b01) begin
      errors++;
      $display("FAIL midread_reset: valid/empty=%b%b expected 01", rd_valid0, rd_empty0);
    end
    reset = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    int exp;
    do_reset();
    write_frame(1);
    step();
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr_en   = (k >= 4 && k <= 7);
      data_in = 5 + k - 4;
      step();
      exp = (k < 12) ? (k % 4) + 1 : k - 12 + 5;
      checks++;
      if ({rd_valid1, data_out1} !== {1'b1, 32'(exp)}) begin
        errors++;
        $display("FAIL simul_rep[%0d]: valid=%b data=%0d expected 1 %0d", k, rd_valid1, data_out1, exp);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;

    do_reset();
    write_frame(1);
    step();
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; data_in = 5 + k;
      step();
      checks++;
      if ({rd_valid0, data_out0} !== {1'b1, 32'(k + 1)}) begin
        errors++;
        $display("FAIL simul_norep[%0d]: valid=%b data=%0d expected 1 %0d", k, rd_valid0, data_out0, k + 1);
      end
    end
    wr_en = 1'b0;
    checks++;
    if (rd_empty0 !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_pulse: rd_empty=%b expected 1", rd_empty0);
    end
    step();
    checks++;
    if ({rd_valid0, rd_empty0} !== 2'b00) begin
      errors++;
      $display("FAIL simul_reclaim: valid/empty=%b%b expected 00", rd_valid0, rd_empty0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({rd_valid0, rd_sof0, data_out0} !== {1'b1, k == 0, 32'(k + 5)}) begin
        errors++;
        $display("FAIL simul_new[%0d]: valid=%b sof=%b data=%0d expected 1 %b %0d",
                 k, rd_valid0, rd_sof0, data_out0, k == 0, k + 5);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_last();
    test_overflow();
    test_sof_and_reset();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
